rv32_exec_datapath: RTL and testbench

RV32_EXEC_DATAPATH -- requirements
Module: rv32_exec_datapath

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/rv32_alu_core.sv | 32 +++
 rtl/rv32_exec_datapath.sv | 69 ++++++
 tb/tb_rv32_exec_datapath.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared opcode encodings and widths for the rv32 execute datapath
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_fmt_e;

endpackage

// File: rtl/rv32_alu_core.sv
// rtl/rv32_alu_core.sv - combinational 32-bit integer ALU
module rv32_alu_core
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_sel,
  output logic [XLEN-1:0] alu_result
);

  logic [4:0] shamt;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_sel))
      ALU_ADD:    alu_result = alu_a + alu_b;
      ALU_SUB:    alu_result = alu_a - alu_b;
      ALU_SLL:    alu_result = alu_a << shamt;
      ALU_SRL:    alu_result = alu_a >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:    alu_result = alu_a ^ alu_b;
      ALU_OR:     alu_result = alu_a | alu_b;
      ALU_AND:    alu_result = alu_a & alu_b;
      ALU_PASS_B: alu_result = alu_b;
      default:    alu_result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_exec_datapath.sv
// rtl/rv32_exec_datapath.sv - immediate generator, ALU and word-wide data memory
module rv32_exec_datapath
  import rv32_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_LSB  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [2:0]  imm_sel,
  output logic [31:0] immediate,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_sel,
  output logic [31:0] alu_result,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_rw,
  output logic [31:0] mem_rdata
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Opcode bits and out-of-range address bits are intentionally dropped.
  logic bits_unused;
  assign bits_unused = ^{instr[6:0], mem_addr};

  always_comb begin
    immediate = '0;
    case (imm_fmt_e'(imm_sel))
      IMM_I: immediate = {{20{instr[31]}}, instr[31:20]};
      IMM_S: immediate = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: immediate = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: immediate = {instr[31:12], 12'b0};
      IMM_J: immediate = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immediate = '0;
    endcase
  end

  rv32_alu_core u_alu (
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result)
  );

  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_q [MEM_WORDS];
  logic [31:0]      mem_d [MEM_WORDS];

  assign mem_idx   = mem_addr[ADDR_LSB +: IDX_W];
  assign mem_rdata = mem_q[mem_idx];

  always_comb begin
    mem_d = mem_q;
    if (mem_rw) mem_d[mem_idx] = mem_wdata;
  end

  // Reset clears the whole array and overrides any write landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// tb/tb_rv32_exec_datapath.sv - randomized model-checked bench for rv32_exec_datapath
module tb_rv32_exec_datapath;

  localparam int MW = 256;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [31:0] immediate;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  logic [31:0] ref_mem [MW];

  rv32_exec_datapath #(.MEM_WORDS(MW), .ADDR_LSB(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .imm_sel    (imm_sel),
    .immediate  (immediate),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int word_of(logic [31:0] addr);
    return int'((addr >> 2) % MW);
  endfunction

  function automatic logic [31:0] imm_ref(logic [31:0] ins, logic [2:0] sel);
    int v;
    case (sel)
      3'd0: v = int'($signed(ins)) >>> 20;
      3'd1: v = ((int'($signed(ins)) >>> 25) * 32) + int'((ins >> 7) & 32'h1f);
      3'd2: v = (int'($signed(ins)) >>> 31) * 4096 + int'(ins[7]) * 2048
               + int'((ins >> 25) & 32'h3f) * 32 + int'((ins >> 8) & 32'hf) * 2;
      3'd3: v = int'(ins & 32'hFFFFF000);
      3'd4: v = (int'($signed(ins)) >>> 31) * 1048576 + int'((ins >> 12) & 32'hff) * 4096
               + int'(ins[20]) * 2048 + int'((ins >> 21) & 32'h3ff) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    int unsigned sh;
    int sa;
    int sb;
    sh = b % 32;
    sa = int'(a);
    sb = int'(b);
    case (s)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 32'd1);
      4'd2:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa >>> sh);
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MW; i++) ref_mem[i] <= '0;
    end else if (mem_rw) begin
      ref_mem[word_of(mem_addr)] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rand_imm", immediate, imm_ref(instr, imm_sel));
      chk("rand_alu", alu_result, alu_ref(alu_a, alu_b, alu_sel));
      chk("rand_mem", mem_rdata, ref_mem[word_of(mem_addr)]);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; instr = 0; imm_sel = 0; alu_a = 0; alu_b = 0; alu_sel = 0;
    mem_addr = 0; mem_wdata = 0; mem_rw = 0;
    #1 rst = 0;
    #1;
    chk("rst_mem_0", mem_rdata, 32'h0);
    mem_addr = 32'h3FC; #1 chk("rst_mem_top", mem_rdata, 32'h0);

    imm_sel = 3'b000; instr = 32'hFFF00093; #1 chk("imm_i", immediate, 32'hFFFFFFFF);
    imm_sel = 3'b011; instr = 32'h123450B7; #1 chk("imm_u", immediate, 32'h12345000);
    // instr[7]=1 supplies immediate bit 11, so the B value here is all ones above bit 2
    imm_sel = 3'b010; instr = 32'hFE000EE3; #1 chk("imm_b", immediate, 32'hFFFFFFFC);
    imm_sel = 3'b100; instr = 32'h0080006F; #1 chk("imm_j", immediate, 32'h00000008);
    imm_sel = 3'b101; #1 chk("imm_rsvd", immediate, 32'h0);

    alu_a = 32'h80000000; alu_b = 1;
    alu_sel = 4'b0011; #1 chk("alu_slt", alu_result, 32'd1);
    alu_sel = 4'b0100; #1 chk("alu_sltu", alu_result, 32'd0);
    alu_sel = 4'b0111; alu_b = 4; #1 chk("alu_sra", alu_result, 32'hF8000000);
    alu_sel = 4'b0001; alu_a = 0; alu_b = 1; #1 chk("alu_sub", alu_result, 32'hFFFFFFFF);
    alu_sel = 4'b1100; alu_a = 32'h1234; #1 chk("alu_rsvd", alu_result, 32'h0);

    mem_rw = 1; mem_addr = 20; mem_wdata = 32'hAAAA5555;
    tick();
    rst = 1; mem_rw = 0;
    #1 chk("wr_in_reset", mem_rdata, 32'h0);

    tick();
    mem_rw = 1; mem_addr = 8; mem_wdata = 32'hDEADBEEF;
    #1 chk("rdw_old", mem_rdata, 32'h0);
    tick();
    mem_rw = 0;
    #1 chk("wr_8", mem_rdata, 32'hDEADBEEF);
    mem_addr = 8 + 4 * MW; #1 chk("wr_8_wrap", mem_rdata, 32'hDEADBEEF);
    mem_addr = 11; #1 chk("wr_8_lowbits", mem_rdata, 32'hDEADBEEF);

    mem_rw = 1; mem_addr = 4; mem_wdata = 32'h1234;
    tick();
    mem_rw = 0;
    #1 chk("wr_4", mem_rdata, 32'h1234);
    rst = 0;
    #1 chk("async_rst_4", mem_rdata, 32'h0);
    mem_addr = 8; #1 chk("async_rst_8", mem_rdata, 32'h0);
    rst = 1;

    tick();
    mem_rw = 1; mem_addr = 12; mem_wdata = 32'hCAFEF00D;
    rst = 0;
    tick();
    rst = 1; mem_rw = 0;
    #1 chk("rst_beats_wr", mem_rdata, 32'h0);

    mem_rw = 1; mem_addr = 16; mem_wdata = 32'h600DF00D;
    tick();
    mem_rw = 0;
    for (int i = 0; i < 3; i++) begin
      mem_wdata = $urandom;
      tick();
    end
    #1 chk("rd_no_write", mem_rdata, 32'h600DF00D);

    tick();
    cmp_en = 1;
    repeat (600) begin
      instr     = $urandom;
      imm_sel   = 3'($urandom_range(0, 7));
      alu_a     = pick_operand();
      alu_b     = pick_operand();
      alu_sel   = 4'($urandom_range(0, 15));
      mem_addr  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
      mem_wdata = $urandom;
      mem_rw    = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 39) != 0);
      tick();
    end
    cmp_en = 0;
    rst = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
